decode_regfile: RTL and testbench

//  Decode/register-read stage that sits directly upstream of the ALU.
//  - Accepts 16-bit instructions from fetch, decodes the fields and reads an 8 x 16 register file.
//  - Presents Cond, Op_C, Reg1, Reg2, Ld_Sh and the destination address to the ALU through a one-entry output register.
//  - A scoreboard stalls read-after-write and write-after-write hazards until writeback retires the producer.

---
 rtl/decode_regfile.sv | 133 +++++++++++++
 tb/tb_decode_regfile.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_regfile.sv
// Decode / register-read stage feeding the ALU.
// Decodes 16-bit instructions, reads an 8 x DW register file with writeback
// bypass, tracks in-flight destinations in a busy scoreboard and presents the
// operands through a one-entry output register.
//
// Handshake: In_Valid/In_Ready and Out_Valid/Out_Ready follow strict
// valid/ready rules. A transfer happens on a rising edge where both are high.
// A producer never drops valid or changes data before the transfer. In_Ready
// may depend on In_Valid (hazard stall), but Out_Valid never depends on
// Out_Ready. While Out_Valid && !Out_Ready every output field holds steady.
module decode_regfile #(
  parameter int DW       = 16,
  parameter int STALL_CW = 16
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                In_Valid,
  output logic                In_Ready,
  input  logic [15:0]         Instr,
  output logic                Out_Valid,
  input  logic                Out_Ready,
  output logic [1:0]          Cond,
  output logic [3:0]          Op_C,
  output logic [2:0]          Dest_Addr,
  output logic [DW-1:0]       Reg1,
  output logic [DW-1:0]       Reg2,
  output logic [6:0]          Ld_Sh,
  input  logic                Wb_Valid,
  input  logic                Wb_We,
  input  logic [2:0]          Wb_Addr,
  input  logic [DW-1:0]       Wb_Data,
  output logic [STALL_CW-1:0] Stall_Cnt,
  output logic [7:0]          Busy
);

  logic [DW-1:0] rf [8];
  logic [7:0]    busy;
  logic [3:0]    op;
  logic [2:0]    rd;
  logic [2:0]    rs1;
  logic [2:0]    rs2;
  logic          reads_rs1;
  logic          reads_rs2;
  logic          writes_rd;
  logic [7:0]    wb_clr;
  logic [7:0]    busy_eff;
  logic          stall;
  logic          accept;
  logic [DW-1:0] rd1_val;
  logic [DW-1:0] rd2_val;

  assign op   = Instr[13:10];
  assign rd   = Instr[9:7];
  assign rs1  = Instr[6:4];
  assign rs2  = Instr[3:1];
  assign Busy = busy;

  // Operand-class decode and hazard / handshake evaluation
  always_comb begin
    writes_rd = (op <= 4'd10);
    reads_rs2 = (op <= 4'd5) || (op == 4'd11);
    reads_rs1 = reads_rs2 || ((op >= 4'd7) && (op <= 4'd10));
    // A retiring producer frees its register in the same cycle
    wb_clr    = Wb_Valid ? (8'b1 << Wb_Addr) : 8'b0;
    busy_eff  = busy & ~wb_clr;
    stall     = In_Valid && ((reads_rs1 && busy_eff[rs1]) ||
                             (reads_rs2 && busy_eff[rs2]) ||
                             (writes_rd && busy_eff[rd]));
    In_Ready  = !stall && (!Out_Valid || Out_Ready);
    accept    = In_Valid && In_Ready;
  end

  // Register-file read with same-cycle writeback bypass
  always_comb begin
    rd1_val = rf[rs1];
    rd2_val = rf[rs2];
    if (Wb_Valid && Wb_We && (Wb_Addr == rs1)) rd1_val = Wb_Data;
    if (Wb_Valid && Wb_We && (Wb_Addr == rs2)) rd2_val = Wb_Data;
  end

  // Register-file writes from writeback; R0 is an ordinary register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else if (Wb_Valid && Wb_We) begin
      rf[Wb_Addr] <= Wb_Data;
    end
  end

  // Scoreboard: clear on retire, set on accepting a writer (set wins)
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      busy <= '0;
    end else if (accept && writes_rd) begin
      busy <= busy_eff | (8'b1 << rd);
    end else begin
      busy <= busy_eff;
    end
  end

  // Output register: load on accept, drain on consume, otherwise hold
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Out_Valid <= 1'b0;
      Cond      <= '0;
      Op_C      <= '0;
      Dest_Addr <= '0;
      Reg1      <= '0;
      Reg2      <= '0;
      Ld_Sh     <= '0;
    end else if (accept) begin
      Out_Valid <= 1'b1;
      Cond      <= Instr[15:14];
      Op_C      <= op;
      Dest_Addr <= rd;
      Reg1      <= rd1_val;
      Reg2      <= rd2_val;
      Ld_Sh     <= Instr[6:0];
    end else if (Out_Valid && Out_Ready) begin
      Out_Valid <= 1'b0;
    end
  end

  // Saturating count of cycles lost to hazards
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Stall_Cnt <= '0;
    end else if (stall && (Stall_Cnt != {STALL_CW{1'b1}})) begin
      Stall_Cnt <= Stall_Cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_regfile.sv
// Testbench for decode_regfile: directed instruction vectors, expected ALU
// fields queued at accept time and checked by an independent output monitor.
module tb_decode_regfile;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        In_Valid;
  logic        In_Ready;
  logic [15:0] Instr;
  logic        Out_Valid;
  logic        Out_Ready;
  logic [1:0]  Cond;
  logic [3:0]  Op_C;
  logic [2:0]  Dest_Addr;
  logic [15:0] Reg1;
  logic [15:0] Reg2;
  logic [6:0]  Ld_Sh;
  logic        Wb_Valid;
  logic        Wb_We;
  logic [2:0]  Wb_Addr;
  logic [15:0] Wb_Data;
  logic [15:0] Stall_Cnt;
  logic [7:0]  Busy;

  logic [47:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  decode_regfile #(.DW(16), .STALL_CW(16)) dut (
    .Clk(Clk), .Rst(Rst),
    .In_Valid(In_Valid), .In_Ready(In_Ready), .Instr(Instr),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .Cond(Cond), .Op_C(Op_C), .Dest_Addr(Dest_Addr),
    .Reg1(Reg1), .Reg2(Reg2), .Ld_Sh(Ld_Sh),
    .Wb_Valid(Wb_Valid), .Wb_We(Wb_We), .Wb_Addr(Wb_Addr), .Wb_Data(Wb_Data),
    .Stall_Cnt(Stall_Cnt), .Busy(Busy)
  );

  // clock / reset / watchdog
  always #5 Clk = ~Clk;

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [47:0] mk(logic [1:0] c, logic [3:0] o, logic [2:0] d,
                                     logic [15:0] r1, logic [15:0] r2, logic [6:0] l);
    return {c, o, d, r1, r2, l};
  endfunction

  function automatic logic [47:0] out_vec();
    return {Cond, Op_C, Dest_Addr, Reg1, Reg2, Ld_Sh};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor / scoreboard: compare every transfer against the queue head
  always @(negedge Clk) begin
    if (!Rst && Out_Valid && Out_Ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out: got %h expected none", out_vec());
      end else begin
        logic [47:0] e;
        e = exp_q.pop_front();
        if (out_vec() !== e) begin
          n_fail++;
          $display("FAIL out_fields: got %h expected %h", out_vec(), e);
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wb(input logic [2:0] a, input logic [15:0] d);
    Wb_Valid = 1'b1; Wb_We = 1'b1; Wb_Addr = a; Wb_Data = d;
    tick();
    Wb_Valid = 1'b0; Wb_We = 1'b0;
  endtask

  task automatic issue(input logic [15:0] ins, input logic [47:0] e, output int waited);
    bit ok;
    ok = 0;
    waited = 0;
    In_Valid = 1'b1;
    Instr    = ins;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      if (In_Ready) begin
        exp_q.push_back(e);
        ok = 1;
        break;
      end
      waited++;
    end
    tick();
    In_Valid = 1'b0;
    chk("issue_accepted", 64'(ok), 64'd1);
  endtask

  int w;

  initial begin
    Rst = 1'b1; In_Valid = 1'b0; Instr = '0; Out_Ready = 1'b1;
    Wb_Valid = 1'b0; Wb_We = 1'b0; Wb_Addr = '0; Wb_Data = '0;
    tick(); tick();
    // reset state
    chk("rst_out_valid", 64'(Out_Valid), 64'd0);
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_stall_cnt", 64'(Stall_Cnt), 64'd0);
    chk("rst_fields", 64'(out_vec()), 64'd0);
    chk("rst_in_ready", 64'(In_Ready), 64'd1);
    Rst = 1'b0;
    tick();

    // R3 = 0x1234, then ADD R1,R3,R3
    wb(3'd3, 16'h1234);
    issue(16'h00B6, mk(2'd0, 4'h0, 3'd1, 16'h1234, 16'h1234, 7'h36), w);
    chk("add_out_valid", 64'(Out_Valid), 64'd1);
    chk("add_busy1", 64'(Busy), 64'h02);
    wb(3'd1, 16'h0011);
    chk("retire_r1", 64'(Busy), 64'h00);

    // writer of R2, then MOV R4,R2 stalls until R2 retires with bypass
    issue(16'h0100, mk(2'd0, 4'h0, 3'd2, 16'h0000, 16'h0000, 7'h00), w);
    chk("busy_r2", 64'(Busy), 64'h04);
    In_Valid = 1'b1; Instr = 16'h1E20;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("raw_stall_in_ready", 64'(In_Ready), 64'd0);
      tick();
    end
    Wb_Valid = 1'b1; Wb_We = 1'b1; Wb_Addr = 3'd2; Wb_Data = 16'h00FF;
    @(negedge Clk);
    chk("raw_release_in_ready", 64'(In_Ready), 64'd1);
    if (In_Ready) exp_q.push_back(mk(2'd0, 4'h7, 3'd4, 16'h00FF, 16'h0000, 7'h20));
    tick();
    In_Valid = 1'b0; Wb_Valid = 1'b0; Wb_We = 1'b0;
    chk("raw_stall_cnt", 64'(Stall_Cnt), 64'd3);
    chk("raw_busy", 64'(Busy), 64'h10);
    wb(3'd4, 16'hABCD);

    // backpressure: SUB R5,R2,R3 held for 3 cycles, AND R6,R4,R3 waiting
    issue(16'h86A6, mk(2'd2, 4'h1, 3'd5, 16'h00FF, 16'h1234, 7'h26), w);
    Out_Ready = 1'b0;
    In_Valid = 1'b1; Instr = 16'h4B46;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("bp_in_ready", 64'(In_Ready), 64'd0);
      chk("bp_out_valid", 64'(Out_Valid), 64'd1);
      chk("bp_hold", 64'(out_vec()), 64'(mk(2'd2, 4'h1, 3'd5, 16'h00FF, 16'h1234, 7'h26)));
      tick();
    end
    Out_Ready = 1'b1;
    @(negedge Clk);
    chk("bp_release_in_ready", 64'(In_Ready), 64'd1);
    if (In_Ready) exp_q.push_back(mk(2'd1, 4'h2, 3'd6, 16'hABCD, 16'h1234, 7'h46));
    tick();
    In_Valid = 1'b0;
    chk("bp_stall_cnt", 64'(Stall_Cnt), 64'd3);
    chk("bp_busy", 64'(Busy), 64'h60);
    wb(3'd5, 16'h5555);
    wb(3'd6, 16'h6666);

    // no-source MOVn R5 while R7 busy; then a WAW on R5
    issue(16'h2380, mk(2'd0, 4'h8, 3'd7, 16'h0000, 16'h0000, 7'h00), w);
    chk("busy_r7", 64'(Busy), 64'h80);
    issue(16'h1AFF, mk(2'd0, 4'h6, 3'd5, 16'h0000, 16'h0000, 7'h7F), w);
    chk("movn_no_wait", 64'(w), 64'd0);
    chk("movn_busy", 64'(Busy), 64'hA0);
    In_Valid = 1'b1; Instr = 16'h0280;
    @(negedge Clk);
    chk("waw_in_ready", 64'(In_Ready), 64'd0);
    tick();
    Wb_Valid = 1'b1; Wb_We = 1'b1; Wb_Addr = 3'd5; Wb_Data = 16'h0777;
    @(negedge Clk);
    chk("waw_release_in_ready", 64'(In_Ready), 64'd1);
    if (In_Ready) exp_q.push_back(mk(2'd0, 4'h0, 3'd5, 16'h0000, 16'h0000, 7'h00));
    tick();
    In_Valid = 1'b0; Wb_Valid = 1'b0; Wb_We = 1'b0;
    chk("waw_stall_cnt", 64'(Stall_Cnt), 64'd4);
    chk("waw_busy_set_wins", 64'(Busy), 64'hA0);

    // same-cycle retire and re-issue of R6, reading R6 through the bypass
    issue(16'h0300, mk(2'd0, 4'h0, 3'd6, 16'h0000, 16'h0000, 7'h00), w);
    chk("busy_r6", 64'(Busy), 64'hE0);
    In_Valid = 1'b1; Instr = 16'h0360;
    Wb_Valid = 1'b1; Wb_We = 1'b1; Wb_Addr = 3'd6; Wb_Data = 16'h6060;
    @(negedge Clk);
    chk("r6_same_cycle_in_ready", 64'(In_Ready), 64'd1);
    if (In_Ready) exp_q.push_back(mk(2'd0, 4'h0, 3'd6, 16'h6060, 16'h0000, 7'h60));
    tick();
    In_Valid = 1'b0; Wb_Valid = 1'b0; Wb_We = 1'b0;
    chk("r6_set_wins", 64'(Busy), 64'hE0);
    chk("r6_stall_cnt", 64'(Stall_Cnt), 64'd4);

    // reset while an entry is held
    issue(16'h3000, mk(2'd0, 4'hC, 3'd0, 16'h0000, 16'h0000, 7'h00), w);
    Out_Ready = 1'b0;
    tick();
    chk("pre_rst_out_valid", 64'(Out_Valid), 64'd1);
    Rst = 1'b1;
    #1;
    exp_q.delete();
    chk("mid_rst_out_valid", 64'(Out_Valid), 64'd0);
    chk("mid_rst_busy", 64'(Busy), 64'd0);
    chk("mid_rst_stall_cnt", 64'(Stall_Cnt), 64'd0);
    tick();
    Rst = 1'b0;
    Out_Ready = 1'b1;
    tick();
    issue(16'h2C36, mk(2'd0, 4'hB, 3'd0, 16'h0000, 16'h0000, 7'h36), w);
    chk("post_rst_busy", 64'(Busy), 64'd0);

    tick(); tick(); tick();
    chk("drain", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
